// File: rtl/spk_host_bridge_if.sv
// Host/SRAM-facing signal bundle of spk_host_bridge: command, load stream,
// readback stream, both spike SRAM ports and status pulses.
interface spk_host_bridge_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned LEN_W  = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_op;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;

    logic [15:0]       s_data;
    logic              s_valid;
    logic              s_ready;

    logic [127:0]      in_spk_write_sram;
    logic [ADDR_W-1:0] in_spk_write_sram_addr;
    logic              in_spk_write_sram_we;

    logic [15:0]       spk_read_sram;
    logic [ADDR_W-1:0] spk_read_sram_addr;

    logic [15:0]       m_data;
    logic              m_valid;
    logic              m_ready;

    logic              busy;
    logic              done;
    logic              err;

    // Host / SRAM fabric side
    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_len,
        output s_data, s_valid,
        output spk_read_sram,
        output m_ready,
        input  cmd_ready, s_ready,
        input  in_spk_write_sram, in_spk_write_sram_addr, in_spk_write_sram_we,
        input  spk_read_sram_addr,
        input  m_data, m_valid,
        input  busy, done, err
    );

    // Bridge side
    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_len,
        input  s_data, s_valid,
        input  spk_read_sram,
        input  m_ready,
        output cmd_ready, s_ready,
        output in_spk_write_sram, in_spk_write_sram_addr, in_spk_write_sram_we,
        output spk_read_sram_addr,
        output m_data, m_valid,
        output busy, done, err
    );
endinterface

// File: rtl/spk_host_bridge.sv
// Host bridge for the accelerator spike SRAMs: packs 16-bit host words into
// 128-bit input-spike rows, and streams output-spike words back to the host.
module spk_host_bridge #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned LEN_W  = 10
) (
    input logic             clk,
    input logic             reset,
    spk_host_bridge_if.slave bus
);
    localparam int unsigned WORD_W = 16;
    localparam int unsigned ROW_W  = 128;
    localparam int unsigned WPR    = ROW_W / WORD_W;
    localparam int unsigned PACK_W = ROW_W - WORD_W;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LOAD       = 3'd1;
    localparam logic [2:0] ST_LOAD_FLUSH = 3'd2;
    localparam logic [2:0] ST_RD_REQ     = 3'd3;
    localparam logic [2:0] ST_RD_WAIT    = 3'd4;
    localparam logic [2:0] ST_RD_OUT     = 3'd5;
    localparam logic [2:0] ST_FIN        = 3'd6;

    logic [2:0]        state_q,   state_nxt;
    logic [ADDR_W-1:0] base_q,    base_nxt;
    logic [LEN_W-1:0]  len_q,     len_nxt;
    logic [LEN_W-1:0]  row_q,     row_nxt;
    logic [LEN_W-1:0]  idx_q,     idx_nxt;
    logic [2:0]        word_q,    word_nxt;
    logic [PACK_W-1:0] pack_q,    pack_nxt;
    logic [ROW_W-1:0]  wr_data_q, wr_data_nxt;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
    logic              wr_we_q,   wr_we_nxt;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_nxt;
    logic [WORD_W-1:0] m_data_q,  m_data_nxt;
    logic              m_valid_q, m_valid_nxt;
    logic              busy_q,    busy_nxt;
    logic              done_q,    done_nxt;
    logic              err_q,     err_nxt;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            row_q     <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            pack_q    <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            wr_we_q   <= 1'b0;
            rd_addr_q <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            base_q    <= base_nxt;
            len_q     <= len_nxt;
            row_q     <= row_nxt;
            idx_q     <= idx_nxt;
            word_q    <= word_nxt;
            pack_q    <= pack_nxt;
            wr_data_q <= wr_data_nxt;
            wr_addr_q <= wr_addr_nxt;
            wr_we_q   <= wr_we_nxt;
            rd_addr_q <= rd_addr_nxt;
            m_data_q  <= m_data_nxt;
            m_valid_q <= m_valid_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt   = state_q;
        base_nxt    = base_q;
        len_nxt     = len_q;
        row_nxt     = row_q;
        idx_nxt     = idx_q;
        word_nxt    = word_q;
        pack_nxt    = pack_q;
        wr_data_nxt = wr_data_q;
        wr_addr_nxt = wr_addr_q;
        wr_we_nxt   = 1'b0;
        rd_addr_nxt = rd_addr_q;
        m_data_nxt  = m_data_q;
        m_valid_nxt = m_valid_q;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0) begin
                        err_nxt = 1'b1;
                    end else begin
                        base_nxt = bus.cmd_base;
                        len_nxt  = bus.cmd_len;
                        row_nxt  = '0;
                        idx_nxt  = '0;
                        word_nxt = '0;
                        pack_nxt = '0;
                        if (bus.cmd_op) begin
                            // Address presented during RD_REQ so data lands in RD_WAIT
                            rd_addr_nxt = bus.cmd_base;
                            state_nxt   = ST_RD_REQ;
                        end else begin
                            state_nxt   = ST_LOAD;
                        end
                    end
                end
            end

            ST_LOAD: begin
                if (bus.s_valid) begin
                    if (word_q == 3'(WPR - 1)) begin
                        wr_we_nxt   = 1'b1;
                        wr_data_nxt = {bus.s_data, pack_q};
                        wr_addr_nxt = base_q + ADDR_W'(row_q);
                        word_nxt    = '0;
                        row_nxt     = row_q + LEN_W'(1);
                        if (row_q == len_q - LEN_W'(1)) begin
                            state_nxt = ST_LOAD_FLUSH;
                        end
                    end else begin
                        for (int k = 0; k < int'(WPR) - 1; k++) begin
                            if (word_q == 3'(k)) begin
                                pack_nxt[k*WORD_W +: WORD_W] = bus.s_data;
                            end
                        end
                        word_nxt = word_q + 3'd1;
                    end
                end
            end

            // Final row strobe is already on the port; let it retire
            ST_LOAD_FLUSH: state_nxt = ST_FIN;

            ST_RD_REQ: state_nxt = ST_RD_WAIT;

            ST_RD_WAIT: begin
                m_data_nxt  = bus.spk_read_sram;
                m_valid_nxt = 1'b1;
                state_nxt   = ST_RD_OUT;
            end

            ST_RD_OUT: begin
                if (bus.m_ready) begin
                    m_valid_nxt = 1'b0;
                    idx_nxt     = idx_q + LEN_W'(1);
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_nxt = ST_FIN;
                    end else begin
                        rd_addr_nxt = base_q + ADDR_W'(idx_q + LEN_W'(1));
                        state_nxt   = ST_RD_REQ;
                    end
                end
            end

            ST_FIN: begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    assign bus.cmd_ready              = (state_q == ST_IDLE);
    assign bus.s_ready                = (state_q == ST_LOAD);
    assign bus.in_spk_write_sram      = wr_data_q;
    assign bus.in_spk_write_sram_addr = wr_addr_q;
    assign bus.in_spk_write_sram_we   = wr_we_q;
    assign bus.spk_read_sram_addr     = rd_addr_q;
    assign bus.m_data                 = m_data_q;
    assign bus.m_valid                = m_valid_q;
    assign bus.busy                   = busy_q;
    assign bus.done                   = done_q;
    assign bus.err                    = err_q;
endmodule

// File: doc/spk_host_bridge.md
Name: spk_host_bridge

Overview:
Host-side counterpart to the accelerator's spike SRAM ports.
- Load path: accepts a 16-bit host word stream, packs 8 words per row into 128-bit rows, and writes them into the input-spike SRAM that the accelerator reads.
- Readback path: reads the 16-bit output-spike SRAM that the accelerator writes, and streams the words back to the host.
- Sits between the host/testbench fabric and the SRAM macros, and runs only while the accelerator is idle.

Parameters:
- ADDR_W, 9, SRAM row address width; all addresses wrap modulo 2^ADDR_W.
- LEN_W, 10, width of cmd_len; maximum length is 2^ADDR_W rows or words.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = LOAD input spikes, 1 = READBACK output spikes.
- cmd_base  in  ADDR_W  first SRAM address.
- cmd_len  in  LEN_W  LOAD: number of 128-bit rows; READBACK: number of 16-bit words.
- s_data  in  16  load stream word.
- s_valid  in  1  load word valid.
- s_ready  out  1  load word accepted when s_valid && s_ready.
- in_spk_write_sram  out  128  row write data.
- in_spk_write_sram_addr  out  ADDR_W  row write address.
- in_spk_write_sram_we  out  1  row write strobe, one cycle per row.
- spk_read_sram  in  16  output-spike SRAM read data, one-cycle synchronous latency.
- spk_read_sram_addr  out  ADDR_W  output-spike SRAM read address.
- m_data  out  16  readback word.
- m_valid  out  1  readback word valid.
- m_ready  in  1  host accepts readback word.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse when a command with cmd_len == 0 is received.

Behaviour:
- Reset (reset low, async):
  - State = IDLE.
  - All outputs 0 except cmd_ready = 1.
  - Address, word and row counters = 0; pack register cleared.
  - Any partial row or pending word is discarded and no write strobe is issued.
- Registered outputs: all outputs are registered except cmd_ready and s_ready, which are decoded from state.
- FSM states: IDLE, LOAD, LOAD_FLUSH, RD_REQ, RD_WAIT, RD_OUT, FIN.
- IDLE:
  - On cmd_valid, latch base, len and op.
  - len == 0: err = 1 for the next cycle, stay in IDLE, no SRAM activity.
  - op = 0 -> LOAD; op = 1 -> RD_REQ.
  - cmd_valid is ignored in every other state.
- LOAD:
  - s_ready = 1.
  - Accepted word k (k = 0..7 within the row) occupies bits [16k+15:16k]; word 0 goes to the LSBs.
  - On acceptance of word 7, the next cycle has:
    - in_spk_write_sram_we = 1;
    - in_spk_write_sram = the full row;
    - in_spk_write_sram_addr = base + row (mod 2^ADDR_W).
  - The row counter then increments. s_ready stays high across row boundaries, so there is no bubble.
  - Acceptance of the last word of the last row -> LOAD_FLUSH, with s_ready = 0 from that cycle on.
- LOAD_FLUSH: issues the final write strobe, then -> FIN.
- RD_REQ: spk_read_sram_addr = base + idx (mod 2^ADDR_W) -> RD_WAIT.
- RD_WAIT: capture spk_read_sram into m_data, set m_valid = 1 -> RD_OUT.
- RD_OUT:
  - m_data is held stable and m_valid stays 1 until m_ready.
  - On handshake: m_valid = 0 and idx increments.
  - If idx == len - 1, go to FIN; otherwise go to RD_REQ.
  - Throughput is at most 1 word per 3 cycles.
- FIN: done = 1 for one cycle -> IDLE.
- Wrap-around: base + offset past 2^ADDR_W - 1 wraps to 0 with no error.
- cmd_len = 2^ADDR_W is legal and covers every address exactly once.
- busy rises the cycle after command acceptance and falls in the same cycle done pulses.

Test Plan:
- LOAD, base 5, len 1, words 0x0001..0x0008 with s_valid held high -> exactly one we; addr 5; data 0x0008_0007_0006_0005_0004_0003_0002_0001; done 2 cycles after the last accept; busy low afterwards.
- LOAD, base 511, len 2, 16 words with random s_valid gaps -> two we pulses, at addr 511 then addr 0; s_ready = 0 after the 16th accept.
- READBACK, base 10, len 3, SRAM model returns 0xA000 + addr, m_ready low for 4 cycles on word 1 -> m_data sequence 0xA00A, 0xA00B, 0xA00C; m_data stable while stalled; exactly 3 handshakes, then done.
- cmd_len = 0 (either op) -> err pulse of one cycle, no we, no done, cmd_ready = 1 again on the next cycle.
- Reset asserted after 4 words of a LOAD row -> outputs return to reset values immediately; no we ever issued; a new LOAD, base 0, len 1 then packs from word 0.
- cmd_valid pulsed during an active READBACK -> ignored; the original sequence completes unchanged.
